// File: rtl/shift_arbiter_if.sv
// rtl/shift_arbiter_if.sv - requester, shifter and response signals of shift_arbiter
// master = requesters/shifter/consumer side, slave = the arbiter itself.
interface shift_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 5
);
  logic             r0_valid;
  logic             r0_ready;
  logic [WIDTH-1:0] r0_in;
  logic [AMT_W-1:0] r0_amt;
  logic             r0_mode;
  logic             r0_dir;

  logic             r1_valid;
  logic             r1_ready;
  logic [WIDTH-1:0] r1_in;
  logic [AMT_W-1:0] r1_amt;
  logic             r1_mode;
  logic             r1_dir;

  logic [WIDTH-1:0] sh_in;
  logic [AMT_W-1:0] sh_amt;
  logic             sh_mode;
  logic             sh_dir;
  logic [WIDTH-1:0] sh_out;

  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_data;
  logic             resp_id;

  modport master (
    output r0_valid, r0_in, r0_amt, r0_mode, r0_dir,
    input  r0_ready,
    output r1_valid, r1_in, r1_amt, r1_mode, r1_dir,
    input  r1_ready,
    input  sh_in, sh_amt, sh_mode, sh_dir,
    output sh_out,
    input  resp_valid, resp_data, resp_id,
    output resp_ready
  );

  modport slave (
    input  r0_valid, r0_in, r0_amt, r0_mode, r0_dir,
    output r0_ready,
    input  r1_valid, r1_in, r1_amt, r1_mode, r1_dir,
    output r1_ready,
    output sh_in, sh_amt, sh_mode, sh_dir,
    input  sh_out,
    output resp_valid, resp_data, resp_id,
    input  resp_ready
  );
endinterface

// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - two-requester arbiter for a shared barrel shifter, registered response
// SHIFT_ARB_FIXED_PRI_EN: requester 0 always wins ties (default: round-robin).
module shift_arbiter #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 5
) (
  input logic           clk,
  input logic           reset,
  shift_arbiter_if.slave bus
);
  logic can_accept;
  logic g0;
  logic g1;
  logic accept;

`ifdef SHIFT_ARB_FIXED_PRI_EN
  assign g0 = bus.r0_valid;
`else
  // last_grant=1 means requester 1 was served last, so requester 0 owns the next tie.
  logic last_grant;
  assign g0 = bus.r0_valid && (!bus.r1_valid || last_grant);
`endif
  assign g1 = bus.r1_valid && !g0;

  assign can_accept   = !bus.resp_valid || bus.resp_ready;
  assign bus.r0_ready = !reset && can_accept && g0;
  assign bus.r1_ready = !reset && can_accept && g1;
  assign accept       = bus.r0_ready || bus.r1_ready;

  always_comb begin
    bus.sh_in   = '0;
    bus.sh_amt  = '0;
    bus.sh_mode = 1'b0;
    bus.sh_dir  = 1'b0;
    if (bus.r0_ready) begin
      bus.sh_in   = bus.r0_in;
      bus.sh_amt  = bus.r0_amt;
      bus.sh_mode = bus.r0_mode;
      bus.sh_dir  = bus.r0_dir;
    end else if (bus.r1_ready) begin
      bus.sh_in   = bus.r1_in;
      bus.sh_amt  = bus.r1_amt;
      bus.sh_mode = bus.r1_mode;
      bus.sh_dir  = bus.r1_dir;
    end
  end

  // An accept in the same cycle as a consumed result overwrites it, keeping one result per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.resp_valid <= 1'b0;
      bus.resp_data  <= '0;
      bus.resp_id    <= 1'b0;
    end else if (accept) begin
      bus.resp_valid <= 1'b1;
      bus.resp_data  <= bus.sh_out;
      bus.resp_id    <= bus.r1_ready;
    end else if (bus.resp_ready) begin
      bus.resp_valid <= 1'b0;
    end
  end

`ifndef SHIFT_ARB_FIXED_PRI_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= bus.r1_ready;
    end
  end
`endif
endmodule

// File: tb/tb_shift_arbiter.sv
// tb/tb_shift_arbiter.sv - scoreboard bench for shift_arbiter with a behavioural shifter
module tb_shift_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [16:0] exp_q[$];
  logic [15:0] sh;

  shift_arbiter_if #(.WIDTH(16), .AMT_W(5)) bus();

  shift_arbiter #(.WIDTH(16), .AMT_W(5)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // Shifter stand-in driven by the arbiter's sh_* outputs
  always_comb begin
    if (int'(bus.sh_amt) >= 16)
      sh = (bus.sh_dir && bus.sh_mode && bus.sh_in[15]) ? 16'hFFFF : 16'h0000;
    else if (!bus.sh_dir)
      sh = bus.sh_in << bus.sh_amt;
    else if (bus.sh_mode)
      sh = 16'($signed(bus.sh_in) >>> bus.sh_amt);
    else
      sh = bus.sh_in >> bus.sh_amt;
  end
  assign bus.sh_out = sh;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int who, input logic v, input logic [15:0] din,
                         input logic [4:0] amt, input logic mode, input logic dir);
    if (who == 0) begin
      bus.r0_valid = v; bus.r0_in = din; bus.r0_amt = amt; bus.r0_mode = mode; bus.r0_dir = dir;
    end else begin
      bus.r1_valid = v; bus.r1_in = din; bus.r1_amt = amt; bus.r1_mode = mode; bus.r1_dir = dir;
    end
  endtask

  // Monitor: every consumed result must match the head of the scoreboard
  always @(negedge clk) begin
    if (!reset && bus.resp_valid && bus.resp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got id %0d data %h expected no response", bus.resp_id, bus.resp_data);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        check("resp_data", 32'(bus.resp_data), 32'(e[15:0]));
        check("resp_id", 32'(bus.resp_id), 32'(e[16]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  typedef struct {
    int          who;
    logic [4:0]  amt;
    logic        mode;
    logic        dir;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[9];

  initial begin
    vecs[0] = '{0, 5'd16, 1'b0, 1'b0, 16'h0000};
    vecs[1] = '{1, 5'd16, 1'b0, 1'b1, 16'h0000};
    vecs[2] = '{0, 5'd16, 1'b1, 1'b1, 16'hFFFF};
    vecs[3] = '{1, 5'd31, 1'b1, 1'b0, 16'h0000};
    vecs[4] = '{0, 5'd31, 1'b0, 1'b1, 16'h0000};
    vecs[5] = '{1, 5'd31, 1'b1, 1'b1, 16'hFFFF};
    vecs[6] = '{0, 5'd0,  1'b0, 1'b0, 16'h8000};
    vecs[7] = '{1, 5'd0,  1'b0, 1'b1, 16'h8000};
    vecs[8] = '{0, 5'd0,  1'b1, 1'b1, 16'h8000};

    // Reset state, with both requesters asking
    reset = 1'b1;
    bus.resp_ready = 1'b0;
    set_req(0, 1'b1, 16'h8000, 5'd1, 1'b1, 1'b1);
    set_req(1, 1'b1, 16'h8000, 5'd1, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check("rst_r0_ready", 32'(bus.r0_ready), 32'd0);
    check("rst_r1_ready", 32'(bus.r1_ready), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_data", 32'(bus.resp_data), 32'd0);
    check("rst_resp_id", 32'(bus.resp_id), 32'd0);
    check("rst_sh_in", 32'(bus.sh_in), 32'd0);
    reset = 1'b0;
    bus.r0_valid = 1'b0;
    bus.r1_valid = 1'b0;

    // r0 alone: 1 << 4
    next();
    set_req(0, 1'b1, 16'h0001, 5'd4, 1'b0, 1'b0);
    bus.resp_ready = 1'b1;
    exp_q.push_back({1'b0, 16'h0010});
    @(negedge clk);
    check("t1_r0_ready", 32'(bus.r0_ready), 32'd1);
    check("t1_r1_ready", 32'(bus.r1_ready), 32'd0);
    check("t1_sh_in", 32'(bus.sh_in), 32'h0001);
    check("t1_sh_amt", 32'(bus.sh_amt), 32'd4);
    next();
    bus.r0_valid = 1'b0;
    @(negedge clk);
    check("t1_resp_valid", 32'(bus.resp_valid), 32'd1);
    next();
    @(negedge clk);
    check("t1_resp_drop", 32'(bus.resp_valid), 32'd0);

    // Both valid every cycle: r0 served last, so r1 leads the alternation
    next();
    set_req(0, 1'b1, 16'h8000, 5'd1, 1'b1, 1'b1);
    set_req(1, 1'b1, 16'h8000, 5'd1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) exp_q.push_back({1'b1, 16'h4000});
      else            exp_q.push_back({1'b0, 16'hC000});
      @(negedge clk);
      check("t2_r0_ready", 32'(bus.r0_ready), 32'(i % 2));
      check("t2_r1_ready", 32'(bus.r1_ready), 32'((i + 1) % 2));
      if (i > 0) check("t2_resp_valid", 32'(bus.resp_valid), 32'd1);
      next();
    end
    bus.r0_valid = 1'b0;
    bus.r1_valid = 1'b0;
    @(negedge clk);
    next();

    // Backpressure: result held, no grants, then r1 (not served last) wins
    set_req(0, 1'b1, 16'h00F0, 5'd4, 1'b0, 1'b1);
    bus.resp_ready = 1'b0;
    exp_q.push_back({1'b0, 16'h000F});
    @(negedge clk);
    check("t3_r0_ready", 32'(bus.r0_ready), 32'd1);
    next();
    set_req(0, 1'b1, 16'h8000, 5'd1, 1'b1, 1'b1);
    set_req(1, 1'b1, 16'h8000, 5'd1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_hold_r0_ready", 32'(bus.r0_ready), 32'd0);
      check("t3_hold_r1_ready", 32'(bus.r1_ready), 32'd0);
      check("t3_hold_data", 32'(bus.resp_data), 32'h000F);
      check("t3_hold_valid", 32'(bus.resp_valid), 32'd1);
      check("t3_hold_sh_in", 32'(bus.sh_in), 32'd0);
      next();
    end
    bus.resp_ready = 1'b1;
    exp_q.push_back({1'b1, 16'h4000});
    @(negedge clk);
    check("t3_release_r0_ready", 32'(bus.r0_ready), 32'd0);
    check("t3_release_r1_ready", 32'(bus.r1_ready), 32'd1);
    next();
    bus.r0_valid = 1'b0;
    bus.r1_valid = 1'b0;
    @(negedge clk);
    next();

    // Boundary amounts on 16'h8000, one requester per cycle, back to back
    for (int i = 0; i < 9; i++) begin
      bus.r0_valid = 1'b0;
      bus.r1_valid = 1'b0;
      set_req(vecs[i].who, 1'b1, 16'h8000, vecs[i].amt, vecs[i].mode, vecs[i].dir);
      exp_q.push_back({vecs[i].who[0], vecs[i].exp});
      @(negedge clk);
      if (vecs[i].who == 0) check("t4_r0_ready", 32'(bus.r0_ready), 32'd1);
      else                  check("t4_r1_ready", 32'(bus.r1_ready), 32'd1);
      next();
    end
    bus.r0_valid = 1'b0;
    bus.r1_valid = 1'b0;
    @(negedge clk);
    next();

    // Reset while a result is pending; r0 was served last, yet r0 wins the first tie after
    bus.resp_ready = 1'b0;
    set_req(0, 1'b1, 16'h1234, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("t5_r0_ready", 32'(bus.r0_ready), 32'd1);
    next();
    bus.r0_valid = 1'b0;
    @(negedge clk);
    check("t5_pending_valid", 32'(bus.resp_valid), 32'd1);
    check("t5_pending_data", 32'(bus.resp_data), 32'h1234);
    #1;
    reset = 1'b1;
    set_req(0, 1'b1, 16'h8000, 5'd1, 1'b1, 1'b1);
    set_req(1, 1'b1, 16'h8000, 5'd1, 1'b0, 1'b1);
    #1;
    check("t5_async_valid", 32'(bus.resp_valid), 32'd0);
    check("t5_async_data", 32'(bus.resp_data), 32'd0);
    check("t5_rst_r0_ready", 32'(bus.r0_ready), 32'd0);
    check("t5_rst_r1_ready", 32'(bus.r1_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.resp_ready = 1'b1;
    exp_q.push_back({1'b0, 16'hC000});
    #1;
    check("t5_tie_r0_ready", 32'(bus.r0_ready), 32'd1);
    check("t5_tie_r1_ready", 32'(bus.r1_ready), 32'd0);
    next();
    bus.r0_valid = 1'b0;
    bus.r1_valid = 1'b0;
    repeat (2) @(negedge clk);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
